// File: rtl/dbus_ram_responder_if.sv
// dbus_ram_responder_if -- CPU data-bus command/response bundle.
//   cmd channel : dBus_cmd_valid/ready handshake with wr, mask, address, data, size payload
//   rsp channel : dBus_rsp_ready one-cycle valid pulse with error flag and read data
//   master      : CPU side (drives the command, receives ready and response)
//   slave       : memory side (receives the command, drives ready and response)
interface dbus_ram_responder_if;
    logic        dBus_cmd_valid;
    logic        dBus_cmd_ready;
    logic        dBus_cmd_payload_wr;
    logic [3:0]  dBus_cmd_payload_mask;
    logic [31:0] dBus_cmd_payload_address;
    logic [31:0] dBus_cmd_payload_data;
    logic [1:0]  dBus_cmd_payload_size;
    logic        dBus_rsp_ready;
    logic        dBus_rsp_error;
    logic [31:0] dBus_rsp_data;

    modport master (
        output dBus_cmd_valid,
        input  dBus_cmd_ready,
        output dBus_cmd_payload_wr,
        output dBus_cmd_payload_mask,
        output dBus_cmd_payload_address,
        output dBus_cmd_payload_data,
        output dBus_cmd_payload_size,
        input  dBus_rsp_ready,
        input  dBus_rsp_error,
        input  dBus_rsp_data
    );

    modport slave (
        input  dBus_cmd_valid,
        output dBus_cmd_ready,
        input  dBus_cmd_payload_wr,
        input  dBus_cmd_payload_mask,
        input  dBus_cmd_payload_address,
        input  dBus_cmd_payload_data,
        input  dBus_cmd_payload_size,
        output dBus_rsp_ready,
        output dBus_rsp_error,
        output dBus_rsp_data
    );
endinterface

// File: rtl/dbus_ram_responder.sv
// dbus_ram_responder -- word-organised RAM answering a CPU data bus.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dbus_ram_responder_if slave (command in, ready/response out)
// Writes complete at the fire edge with no response; reads respond with a one-cycle
// dBus_rsp_ready pulse 1+WAIT_STATES cycles after fire. Out-of-range writes are dropped,
// out-of-range reads respond with error=1 and data=0.
module dbus_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic                 clk,
    input logic                 reset,
    dbus_ram_responder_if.slave bus
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] EndAddr  = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

    stateT            stateQ, stateD;
    logic [3:0]       waitCntQ, waitCntD;
    logic             inRangeQ;
    logic [IdxW-1:0]  idxQ;
    logic             liveQ;    // low until the first edge after reset release

    logic [31:0]      mem [DEPTH_WORDS];

    logic             cmdReady;
    logic             cmdFire;
    logic             addrInRange;
    logic [31:0]      offset;
    logic [IdxW-1:0]  addrIdx;

    // 33-bit compare so the window may touch the top of the address space without wrapping
    assign addrInRange = ({1'b0, bus.dBus_cmd_payload_address} >= {1'b0, BASE_ADDR}) &&
                         ({1'b0, bus.dBus_cmd_payload_address} <  EndAddr);
    assign offset      = bus.dBus_cmd_payload_address - BASE_ADDR;
    assign addrIdx     = offset[IdxW+1:2];

    assign cmdReady = (stateQ == StIdle) && liveQ;
    assign cmdFire  = bus.dBus_cmd_valid && cmdReady;

    always_comb begin
        stateD   = stateQ;
        waitCntD = waitCntQ;
        case (stateQ)
            StIdle: begin
                if (cmdFire && !bus.dBus_cmd_payload_wr) begin
                    if (WAIT_STATES == 0) begin
                        stateD = StResp;
                    end else begin
                        stateD   = StWait;
                        waitCntD = WaitInit;
                    end
                end
            end
            StWait: begin
                waitCntD = waitCntQ - 4'd1;
                if (waitCntQ == 4'd1) begin
                    stateD = StResp;
                end
            end
            StResp:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ   <= StIdle;
            waitCntQ <= 4'd0;
            inRangeQ <= 1'b0;
            idxQ     <= '0;
            liveQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
            liveQ    <= 1'b1;
            if (cmdFire && !bus.dBus_cmd_payload_wr) begin
                inRangeQ <= addrInRange;
                idxQ     <= addrIdx;
            end
        end
    end

    // RAM contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (cmdFire && bus.dBus_cmd_payload_wr && addrInRange) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.dBus_cmd_payload_mask[i]) begin
                    mem[addrIdx][8*i +: 8] <= bus.dBus_cmd_payload_data[8*i +: 8];
                end
            end
        end
    end

    // No command can fire in RESP, so the asynchronous read sees every earlier write
    assign bus.dBus_cmd_ready = cmdReady;
    assign bus.dBus_rsp_ready = (stateQ == StResp);
    assign bus.dBus_rsp_error = (stateQ == StResp) && !inRangeQ;
    assign bus.dBus_rsp_data  = ((stateQ == StResp) && inRangeQ) ? mem[idxQ] : 32'd0;

    logic unusedBits;
    assign unusedBits = ^{bus.dBus_cmd_payload_size, offset[31:IdxW+2], offset[1:0]};

endmodule
